// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter in front of a single-port SRAM macro, with beat-level locking and lock timeout.
// Latency: grant and SRAM drive are combinational in the accept cycle; read data returns one cycle later.
// Backpressure: req_ready is combinational from valid/state/priority; the losing requester simply waits.
module sram_port_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int LOCK_TIMEOUT = 64,
    localparam int STRB_W      = DATA_W / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_write,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    input  logic [2*STRB_W-1:0]   req_wstrb,
    input  logic [1:0]            req_lock,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  lock_abort,
    output logic [STRB_W-1:0]     sram_web,
    output logic [ADDR_W-1:0]     sram_a,
    output logic [DATA_W-1:0]     sram_di,
    input  logic [DATA_W-1:0]     sram_do
);

    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic               pri, pri_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               abort_nxt;
    logic               rd_pend;
    logic               rd_id;

    logic               acc;
    logic               gid;
    logic [ADDR_W-1:0]  g_addr;
    logic [DATA_W-1:0]  g_wdata;
    logic [STRB_W-1:0]  g_wstrb;
    logic               g_write;
    logic               g_lock;

    // Grant: a lock owner excludes the other requester even when it is idle.
    always_comb begin
        req_ready = 2'b00;
        if (!rst) begin
            case (state)
                IDLE: begin
                    case (req_valid)
                        2'b01:   req_ready = 2'b01;
                        2'b10:   req_ready = 2'b10;
                        2'b11:   req_ready = pri ? 2'b10 : 2'b01;
                        default: req_ready = 2'b00;
                    endcase
                end
                LOCK0:   req_ready = {1'b0, req_valid[0]};
                LOCK1:   req_ready = {req_valid[1], 1'b0};
                default: req_ready = 2'b00;
            endcase
        end
    end

    assign acc     = |(req_valid & req_ready);
    assign gid     = req_ready[1];
    assign g_addr  = gid ? req_addr[ADDR_W +: ADDR_W]   : req_addr[0 +: ADDR_W];
    assign g_wdata = gid ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
    assign g_wstrb = gid ? req_wstrb[STRB_W +: STRB_W] : req_wstrb[0 +: STRB_W];
    assign g_write = gid ? req_write[1] : req_write[0];
    assign g_lock  = gid ? req_lock[1]  : req_lock[0];

    always_comb begin
        state_nxt = state;
        pri_nxt   = pri;
        cnt_nxt   = cnt;
        abort_nxt = 1'b0;
        if (acc) begin
            cnt_nxt = '0;
            if (state == IDLE) begin
                pri_nxt = ~gid;
            end
            if (g_lock) begin
                state_nxt = gid ? LOCK1 : LOCK0;
            end else begin
                state_nxt = IDLE;
            end
        end else if (state != IDLE) begin
            // Not accepting while locked means the owner has valid low.
            if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                abort_nxt = 1'b1;
                pri_nxt   = (state == LOCK0);
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end else begin
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pri        <= 1'b0;
            cnt        <= '0;
            rd_pend    <= 1'b0;
            rd_id      <= 1'b0;
            lock_abort <= 1'b0;
        end else begin
            state      <= state_nxt;
            pri        <= pri_nxt;
            cnt        <= cnt_nxt;
            rd_pend    <= acc & ~g_write;
            rd_id      <= gid;
            lock_abort <= abort_nxt;
        end
    end

    // Response lines are gated by reset so a read in flight at reset is dropped.
    always_comb begin
        rsp_valid = 2'b00;
        rsp_rdata = '0;
        if (rd_pend && !rst) begin
            rsp_valid = rd_id ? 2'b10 : 2'b01;
            rsp_rdata = sram_do;
        end
    end

    always_comb begin
        sram_web = '1;
        sram_a   = '0;
        sram_di  = '0;
        if (acc) begin
            sram_a = g_addr;
            if (g_write) begin
                sram_web = ~g_wstrb;
                sram_di  = g_wdata;
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized and directed bench for sram_port_arbiter against an owner/priority reference model.
module tb_sram_port_arbiter;

    localparam int AW  = 14;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req_valid, req_ready, req_write, req_lock, rsp_valid;
    logic [2*AW-1:0]   req_addr;
    logic [2*DW-1:0]   req_wdata;
    logic [2*SW-1:0]   req_wstrb;
    logic [DW-1:0]     rsp_rdata, sram_di, sram_do;
    logic              lock_abort;
    logic [SW-1:0]     sram_web;
    logic [AW-1:0]     sram_a;

    always #5 clk = ~clk;

    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .req_lock   (req_lock),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .lock_abort (lock_abort),
        .sram_web   (sram_web),
        .sram_a     (sram_a),
        .sram_di    (sram_di),
        .sram_do    (sram_do)
    );

    // SRAM macro: synchronous read, byte-masked synchronous write.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        sram_do <= mem[sram_a];
        for (int b = 0; b < SW; b++)
            if (!sram_web[b]) mem[sram_a][b*8 +: 8] <= sram_di[b*8 +: 8];
    end

    // Reference model state
    bit [DW-1:0] ref_mem [0:(1<<AW)-1];
    int          owner = -1;
    bit          pri = 0;
    int          idle = 0;
    bit          pend = 0;
    int          pend_id = 0;
    bit [DW-1:0] pend_dat = '0;
    bit          abort_q = 0;
    bit          armed = 0;

    int n_chk = 0;
    int n_pass = 0;

    logic [1:0]    o_ready, o_rspv;
    logic          o_abort;
    logic [DW-1:0] o_rdata;
    logic [SW-1:0] o_web;
    logic          got_acc, got_g;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic step(input logic [1:0] v, input logic [1:0] w, input logic [1:0] lk,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input logic [SW-1:0] s0, input logic [SW-1:0] s1, input logic r);
        logic [1:0]    e_rdy, e_rspv;
        logic          acc, g;
        logic [AW-1:0] ga;
        logic [DW-1:0] gd, e_di;
        logic [SW-1:0] gs, e_web;
        logic [AW-1:0] e_a;
        @(negedge clk);
        rst = r; req_valid = v; req_write = w; req_lock = lk;
        req_addr = {a1, a0}; req_wdata = {d1, d0}; req_wstrb = {s1, s0};
        #1;
        e_rdy = 2'b00;
        if (!r) begin
            if (owner >= 0) e_rdy[owner] = v[owner];
            else if (v == 2'b11) e_rdy = pri ? 2'b10 : 2'b01;
            else e_rdy = v;
        end
        acc = |(v & e_rdy);
        g   = e_rdy[1];
        ga  = g ? a1 : a0;
        gd  = g ? d1 : d0;
        gs  = g ? s1 : s0;
        e_web = '1; e_a = '0; e_di = '0;
        if (acc) begin
            e_a = ga;
            if (w[g]) begin e_web = ~gs; e_di = gd; end
        end
        check("ready", req_ready, e_rdy);
        check("sram_web", sram_web, e_web);
        check("sram_a", sram_a, e_a);
        check("sram_di", sram_di, e_di);
        if (armed) begin
            e_rspv = (pend && !r) ? (pend_id == 1 ? 2'b10 : 2'b01) : 2'b00;
            check("rsp_valid", rsp_valid, e_rspv);
            check("rsp_rdata", rsp_rdata, (e_rspv != 0) ? pend_dat : '0);
            check("lock_abort", lock_abort, abort_q);
        end
        o_ready = req_ready; o_rspv = rsp_valid; o_abort = lock_abort;
        o_rdata = rsp_rdata; o_web = sram_web; got_acc = acc; got_g = g;
        if (r) begin
            owner = -1; pri = 0; idle = 0; pend = 0; abort_q = 0;
            armed = 1;
        end else begin
            abort_q  = 0;
            pend     = acc && !w[g];
            pend_id  = g;
            pend_dat = ref_mem[ga];
            if (acc) begin
                if (owner < 0) pri = ~g;
                if (w[g])
                    for (int b = 0; b < SW; b++)
                        if (gs[b]) ref_mem[ga][b*8 +: 8] = gd[b*8 +: 8];
                owner = lk[g] ? int'(g) : -1;
                idle = 0;
            end else if (owner >= 0) begin
                idle++;
                if (idle == TMO) begin
                    pri = (owner == 0);
                    owner = -1; idle = 0; abort_q = 1;
                end
            end else begin
                idle = 0;
            end
        end
    endtask

    task automatic nop(input logic r);
        step(2'b00, 2'b00, 2'b00, '0, '0, '0, '0, '0, '0, r);
    endtask

    task automatic do_reset();
        nop(1'b1);
        nop(1'b1);
    endtask

    initial begin
        int n_ab;
        for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
        rst = 1'b1; req_valid = '0; req_write = '0; req_lock = '0;
        req_addr = '0; req_wdata = '0; req_wstrb = '0;

        do_reset();
        nop(1'b0);

        // Alternating grants with both requesters reading every cycle
        for (int i = 0; i < 8; i++) begin
            step(2'b11, 2'b00, 2'b00, AW'(32 + i), AW'(64 + i), '0, '0, '0, '0, 1'b0);
            check("alt_grant", got_g, i % 2);
            check("alt_acc", got_acc, 1);
        end
        nop(1'b0);

        // Partial write then read-back of the same word
        do_reset();
        step(2'b01, 2'b01, 2'b00, 14'h0010, '0, 32'h12345678, '0, 4'hF, '0, 1'b0);
        step(2'b01, 2'b01, 2'b00, 14'h0010, '0, 32'hDEADBEEF, '0, 4'b0011, '0, 1'b0);
        check("strb_web", o_web, 4'b1100);
        step(2'b01, 2'b00, 2'b00, 14'h0010, '0, '0, '0, '0, '0, 1'b0);
        nop(1'b0);
        check("rmw_rspv", o_rspv, 2'b01);
        check("rmw_data", o_rdata, 32'h1234BEEF);

        // Requester 1 holds a lock over four beats while requester 0 waits
        do_reset();
        step(2'b01, 2'b00, 2'b00, 14'h0001, '0, '0, '0, '0, '0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(2'b11, 2'b00, {(k < 3), 1'b0}, 14'h0002, AW'(k), '0, '0, '0, '0, 1'b0);
            check("lock_hold", o_ready, 2'b10);
        end
        step(2'b01, 2'b00, 2'b00, 14'h0002, '0, '0, '0, '0, '0, 1'b0);
        check("lock_release", o_ready, 2'b01);

        // Lock timeout
        do_reset();
        step(2'b01, 2'b00, 2'b01, 14'h0003, '0, '0, '0, '0, '0, 1'b0);
        n_ab = 0;
        for (int k = 0; k < TMO; k++) begin
            nop(1'b0);
            n_ab += int'(o_abort);
        end
        check("abort_early", n_ab, 0);
        step(2'b10, 2'b00, 2'b00, '0, 14'h0004, '0, '0, '0, '0, 1'b0);
        check("abort_pulse", o_abort, 1);
        check("post_abort_grant", o_ready, 2'b10);
        nop(1'b0);
        check("abort_single", o_abort, 0);

        // Reset right after a locked read drops the response
        do_reset();
        step(2'b10, 2'b00, 2'b10, '0, 14'h0005, '0, '0, '0, '0, 1'b0);
        step(2'b10, 2'b00, 2'b10, '0, 14'h0006, '0, '0, '0, '0, 1'b0);
        check("locked_acc", got_acc, 1);
        nop(1'b1);
        check("rst_drop_rsp", o_rspv, 2'b00);
        step(2'b11, 2'b00, 2'b00, 14'h0007, 14'h0008, '0, '0, '0, '0, 1'b0);
        check("rst_no_rsp", o_rspv, 2'b00);
        check("rst_pri0", o_ready, 2'b01);

        // Randomized traffic at several valid densities
        for (int ph = 0; ph < 4; ph++) begin
            int pv;
            pv = (ph == 0) ? 50 : (ph == 1) ? 85 : (ph == 2) ? 4 : 30;
            for (int c = 0; c < 2000; c++) begin
                logic [1:0] v, w, lk;
                v[0] = ($urandom_range(99) < pv);
                v[1] = ($urandom_range(99) < pv);
                w    = 2'($urandom);
                lk   = 2'($urandom);
                step(v, w, lk, AW'($urandom_range(15)), AW'($urandom_range(15)),
                     $urandom, $urandom, SW'($urandom), SW'($urandom),
                     ($urandom_range(299) == 0));
            end
        end
        nop(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14, SRAM word-address width.
REQ-002 Parameter DATA_W, default 32, SRAM data width; STRB_W = DATA_W/8.
REQ-003 Parameter LOCK_TIMEOUT, default 64, idle cycles tolerated from a lock owner before forced release.
REQ-004 CLK  input  1  single clock; all state updates on the rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 REQ_VALID  input  2  per-requester access request; bit i = requester i.
REQ-007 REQ_READY  output  2  per-requester accept; a beat transfers when VALID[i] & READY[i].
REQ-008 REQ_WRITE  input  2  1 = write, 0 = read, per requester.
REQ-009 REQ_ADDR  input  2*ADDR_W  word address; requester i at slice [i*ADDR_W +: ADDR_W].
REQ-010 REQ_WDATA  input  2*DATA_W  write data, sliced per requester.
REQ-011 REQ_WSTRB  input  2*STRB_W  byte enables, sliced per requester; bit 1 = write the byte.
REQ-012 REQ_LOCK  input  2  held with a beat to keep the grant for the following beat.
REQ-013 RSP_VALID  output  2  one-cycle read-data-valid pulse per requester.
REQ-014 RSP_RDATA  output  DATA_W  read data, shared bus, qualified by RSP_VALID.
REQ-015 LOCK_ABORT  output  1  one-cycle pulse on lock-timeout release.
REQ-016 SRAM_WEB  output  STRB_W  active-low byte write enables to the SRAM macro.
REQ-017 SRAM_A  output  ADDR_W  SRAM address.
REQ-018 SRAM_DI  output  DATA_W  SRAM write data.
REQ-019 SRAM_DO  input  DATA_W  SRAM read data, valid the cycle after the address edge.

Function
REQ-020 The FSM SHALL have states IDLE, LOCK0, LOCK1; reset state IDLE.
REQ-021 In IDLE: exactly one VALID -> READY to that requester; both VALID -> READY to requester PRI only; none -> READY = 2'b00.
REQ-022 In LOCKi: READY[i] = VALID[i]; READY[other] = 0 regardless of its VALID.
REQ-023 REQ_READY SHALL be combinational from VALID, state and PRI (no wait states; one beat per cycle maximum).
REQ-024 PRI (1 bit, reset 0) SHALL become ~i after any accepted beat by requester i in IDLE; unchanged in LOCK states.
REQ-025 Accepted beat from i with LOCK[i]=1 -> next state LOCKi; with LOCK[i]=0 -> next state IDLE.
REQ-026 Lock counter (reset 0) SHALL count cycles in LOCKi with VALID[i]=0, clear on any accepted beat, and on reaching LOCK_TIMEOUT SHALL force IDLE and pulse LOCK_ABORT for one cycle; PRI becomes ~i.
REQ-027 Accepted write: SRAM_WEB = ~WSTRB[i], SRAM_A = ADDR[i], SRAM_DI = WDATA[i], same cycle (combinational); no response generated.
REQ-028 Accepted read: SRAM_WEB = all ones, SRAM_A = ADDR[i]; RSP_VALID[i] = 1 exactly one cycle later with RSP_RDATA = SRAM_DO.
REQ-029 No accepted beat: SRAM_WEB = all ones, SRAM_A = 0, SRAM_DI = 0.
REQ-030 WSTRB = 0 on a write SHALL be accepted as a no-op beat (WEB all ones), still updating PRI/FSM.
REQ-031 Back-to-back reads SHALL yield RSP_VALID on consecutive cycles; read after write to same address returns the new data.
REQ-032 RSP_VALID SHALL never assert for both requesters in the same cycle; RSP_RDATA = 0 when RSP_VALID = 0.

Reset
REQ-033 RST high at a clock edge SHALL set state IDLE, PRI 0, lock counter 0, pending read flag 0, LOCK_ABORT 0, RSP_VALID 0 in the next cycle.
REQ-034 RST asserted while in LOCKi or with a read in flight SHALL drop the pending response (no RSP_VALID after reset).
REQ-035 While RST is high, REQ_READY SHALL be 2'b00 and SRAM_WEB all ones.

Verification
REQ-036 Both VALID reads every cycle, LOCK=0 -> grants alternate 0,1,0,1; each RSP_VALID one cycle after its beat.
REQ-037 Req0 writes 0xDEADBEEF at 0x0010 with WSTRB 4'b0011, then reads 0x0010 -> SRAM_WEB 4'b1100; read data low half 0xBEEF, high half unchanged.
REQ-038 Req1 issues 4 reads with LOCK=1,1,1,0 while req0 VALID held -> req0 blocked 4 beats, granted on the 5th cycle.
REQ-039 Req0 takes lock then drops VALID for 64 cycles -> LOCK_ABORT pulses once, req1 granted next cycle.
REQ-040 RST asserted the cycle after a read is accepted in LOCK1 -> no RSP_VALID, state IDLE, PRI 0.
